// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State encoding, grant ids and the latched downstream request record.
package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_WAIT = WAIT
    } state_e;

    localparam logic GNT_IMEM = 1'b0;
    localparam logic GNT_DMEM = 1'b1;

    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and downstream memory channels of the arbiter.
// slave = arbiter view; master = hart plus memory model view.
interface mem_arbiter_if;

    logic        i_imem_req_valid;
    logic        o_imem_req_ready;
    logic [31:0] i_imem_addr;
    logic        o_imem_resp_valid;
    logic [31:0] o_imem_rdata;

    logic        i_dmem_req_valid;
    logic        o_dmem_req_ready;
    logic [31:0] i_dmem_addr;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_resp_valid;
    logic [31:0] o_dmem_rdata;

    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_imem_req_valid, i_imem_addr,
        output o_imem_req_ready, o_imem_resp_valid, o_imem_rdata,
        input  i_dmem_req_valid, i_dmem_addr, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
        output o_dmem_req_ready, o_dmem_resp_valid, o_dmem_rdata,
        output o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_req_ready, i_mem_resp_valid, i_mem_rdata
    );

    modport master (
        output i_imem_req_valid, i_imem_addr,
        input  o_imem_req_ready, o_imem_resp_valid, o_imem_rdata,
        output i_dmem_req_valid, i_dmem_addr, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
        input  o_dmem_req_ready, o_dmem_resp_valid, o_dmem_rdata,
        input  o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_req_ready, i_mem_resp_valid, i_mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit0 = fetch, bit1 = data, one-hot grant.
// Latency: combinational. Backpressure: none, pure function of req and last.
// On contention the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    import mem_arb_pkg::*;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_i == GNT_DMEM) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between fetch and load/store, one transaction at a time.
// Latency: accept at T, downstream valid at T+1, response pulse at T+3 at best.
// Backpressure: requester readys only in IDLE; downstream request held until i_mem_req_ready.
module mem_arbiter #(
    parameter bit DMEM_FIRST = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.slave  bus,
    output logic          o_busy
);
    import mem_arb_pkg::*;

    localparam logic LAST_INIT = DMEM_FIRST ? GNT_IMEM : GNT_DMEM;

    state_e      state_q;
    mem_req_t    req_q, req_d;
    logic        gnt_q, last_q;
    logic        mem_req_vld_q, busy_q;
    logic        imem_resp_q, dmem_resp_q;
    logic [31:0] imem_rdata_q, dmem_rdata_q;
    logic [1:0]  gnt;
    logic        accept_ok, handshake;

    rr_arb2 u_rr (
        .req_i  ({bus.i_dmem_req_valid, bus.i_imem_req_valid}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // Gating with reset keeps the readys low while the block is held in reset.
    assign accept_ok            = i_rst_n && (state_q == ST_IDLE);
    assign bus.o_imem_req_ready = accept_ok & gnt[0];
    assign bus.o_dmem_req_ready = accept_ok & gnt[1];
    assign handshake            = accept_ok & (|gnt);

    always_comb begin
        req_d = '0;
        if (gnt[1]) begin
            req_d.addr  = word_align(bus.i_dmem_addr);
            req_d.wen   = bus.i_dmem_wen;
            req_d.wdata = bus.i_dmem_wdata;
            req_d.mask  = bus.i_dmem_mask;
        end else begin
            req_d.addr  = word_align(bus.i_imem_addr);
            req_d.mask  = MASK_WORD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            gnt_q         <= GNT_IMEM;
            last_q        <= LAST_INIT;
            mem_req_vld_q <= 1'b0;
            busy_q        <= 1'b0;
            imem_resp_q   <= 1'b0;
            dmem_resp_q   <= 1'b0;
            imem_rdata_q  <= '0;
            dmem_rdata_q  <= '0;
        end else begin
            imem_resp_q <= 1'b0;
            dmem_resp_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        req_q         <= req_d;
                        gnt_q         <= gnt[1] ? GNT_DMEM : GNT_IMEM;
                        last_q        <= gnt[1] ? GNT_DMEM : GNT_IMEM;
                        mem_req_vld_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.i_mem_req_ready) begin
                        mem_req_vld_q <= 1'b0;
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_mem_resp_valid) begin
                        if (gnt_q == GNT_DMEM) begin
                            dmem_resp_q  <= 1'b1;
                            dmem_rdata_q <= req_q.wen ? 32'd0 : bus.i_mem_rdata;
                        end else begin
                            imem_resp_q  <= 1'b1;
                            imem_rdata_q <= bus.i_mem_rdata;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_mem_req_valid   = mem_req_vld_q;
    assign bus.o_mem_addr        = req_q.addr;
    assign bus.o_mem_wen         = req_q.wen;
    assign bus.o_mem_wdata       = req_q.wdata;
    assign bus.o_mem_mask        = req_q.mask;
    assign bus.o_imem_resp_valid = imem_resp_q;
    assign bus.o_imem_rdata      = imem_rdata_q;
    assign bus.o_dmem_resp_valid = dmem_resp_q;
    assign bus.o_dmem_rdata      = dmem_rdata_q;
    assign o_busy                = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Inputs change 1 time unit after posedge; outputs are compared on the falling edge.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    mem_arbiter_if bus();

    mem_arbiter #(.DMEM_FIRST(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one pending transaction, its progress, and who was served last.
    bit          m_busy, m_sent, m_gnt_d, m_last_d, m_resp_i, m_resp_d, m_wen;
    logic [31:0] m_addr, m_wdata, m_rdata_i, m_rdata_d;
    logic [3:0]  m_mask;
    int          gnt_log[$];
    int          exp_order[4] = '{1, 0, 1, 0};

    // bit0 = fetch ready, bit1 = data ready
    function automatic logic [1:0] exp_ready();
        if (!rst_n || m_busy) return 2'b00;
        if (bus.i_imem_req_valid && bus.i_dmem_req_valid)
            return m_last_d ? 2'b01 : 2'b10;
        return {bus.i_dmem_req_valid, bus.i_imem_req_valid};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0] w;
        if (!rst_n) begin
            m_busy = 0; m_sent = 0; m_last_d = 0; m_resp_i = 0; m_resp_d = 0;
        end else begin
            w = exp_ready();
            m_resp_i = 0;
            m_resp_d = 0;
            if (!m_busy) begin
                if (w != 2'b00) begin
                    m_busy   = 1;
                    m_sent   = 0;
                    m_gnt_d  = w[1];
                    m_last_d = w[1];
                    if (w[1]) begin
                        m_addr  = bus.i_dmem_addr & ~32'd3;
                        m_wen   = bus.i_dmem_wen;
                        m_wdata = bus.i_dmem_wdata;
                        m_mask  = bus.i_dmem_mask;
                    end else begin
                        m_addr  = bus.i_imem_addr & ~32'd3;
                        m_wen   = 0;
                        m_wdata = 32'd0;
                        m_mask  = 4'hF;
                    end
                end
            end else if (!m_sent) begin
                if (bus.i_mem_req_ready) m_sent = 1;
            end else if (bus.i_mem_resp_valid) begin
                if (m_gnt_d) begin
                    m_resp_d  = 1;
                    m_rdata_d = m_wen ? 32'd0 : bus.i_mem_rdata;
                end else begin
                    m_resp_i  = 1;
                    m_rdata_i = bus.i_mem_rdata;
                end
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] er;
        if (!rst_n) begin
            chk("rst imem_ready",  32'(bus.o_imem_req_ready), 32'd0);
            chk("rst dmem_ready",  32'(bus.o_dmem_req_ready), 32'd0);
            chk("rst mem_valid",   32'(bus.o_mem_req_valid), 32'd0);
            chk("rst busy",        32'(busy), 32'd0);
            chk("rst imem_resp",   32'(bus.o_imem_resp_valid), 32'd0);
            chk("rst dmem_resp",   32'(bus.o_dmem_resp_valid), 32'd0);
            chk("rst mem_addr",    bus.o_mem_addr, 32'd0);
            chk("rst mem_wdata",   bus.o_mem_wdata, 32'd0);
            chk("rst mem_mask",    32'(bus.o_mem_mask), 32'd0);
            chk("rst imem_rdata",  bus.o_imem_rdata, 32'd0);
            chk("rst dmem_rdata",  bus.o_dmem_rdata, 32'd0);
        end else begin
            er = exp_ready();
            chk("imem_ready", 32'(bus.o_imem_req_ready), 32'(er[0]));
            chk("dmem_ready", 32'(bus.o_dmem_req_ready), 32'(er[1]));
            chk("mem_valid",  32'(bus.o_mem_req_valid), 32'(m_busy && !m_sent));
            chk("busy",       32'(busy), 32'(m_busy));
            chk("imem_resp",  32'(bus.o_imem_resp_valid), 32'(m_resp_i));
            chk("dmem_resp",  32'(bus.o_dmem_resp_valid), 32'(m_resp_d));
            if (m_busy && !m_sent) begin
                chk("mem_addr",  bus.o_mem_addr, m_addr);
                chk("mem_wen",   32'(bus.o_mem_wen), 32'(m_wen));
                chk("mem_wdata", bus.o_mem_wdata, m_wdata);
                chk("mem_mask",  32'(bus.o_mem_mask), 32'(m_mask));
            end
            if (m_resp_i) begin
                chk("imem_rdata", bus.o_imem_rdata, m_rdata_i);
                gnt_log.push_back(0);
            end
            if (m_resp_d) begin
                chk("dmem_rdata", bus.o_dmem_rdata, m_rdata_d);
                gnt_log.push_back(1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory side: wait for a request, stall ready, then answer one cycle later.
    task automatic serve(input logic [31:0] rdata, input int ready_delay);
        int n = 0;
        while (!bus.o_mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("serve sees mem request", 32'(bus.o_mem_req_valid), 32'd1);
        repeat (ready_delay) tick();
        bus.i_mem_req_ready = 1'b1;
        tick();
        bus.i_mem_req_ready  = 1'b0;
        bus.i_mem_resp_valid = 1'b1;
        bus.i_mem_rdata      = rdata;
        tick();
        bus.i_mem_resp_valid = 1'b0;
        bus.i_mem_rdata      = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_imem_req_valid = 0; bus.i_imem_addr = 0;
        bus.i_dmem_req_valid = 0; bus.i_dmem_addr = 0; bus.i_dmem_wen = 0;
        bus.i_dmem_wdata = 0; bus.i_dmem_mask = 0;
        bus.i_mem_req_ready = 0; bus.i_mem_resp_valid = 0; bus.i_mem_rdata = 0;

        // A fetch request raised during reset must not see ready.
        bus.i_imem_req_valid = 1'b1;
        repeat (3) tick();
        bus.i_imem_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single fetch with unaligned address
        bus.i_imem_req_valid = 1'b1;
        bus.i_imem_addr      = 32'h0000_1003;
        #1 chk("fetch ready", 32'(bus.o_imem_req_ready), 32'd1);
        tick();
        bus.i_imem_req_valid = 1'b0;
        chk("fetch mem_addr", bus.o_mem_addr, 32'h0000_1000);
        chk("fetch mem_mask", 32'(bus.o_mem_mask), 32'hF);
        chk("fetch mem_wen",  32'(bus.o_mem_wen), 32'd0);
        serve(32'hDEAD_BEEF, 0);
        chk("fetch resp T+3",  32'(bus.o_imem_resp_valid), 32'd1);
        chk("fetch rdata",     bus.o_imem_rdata, 32'hDEAD_BEEF);
        chk("fetch no dmem",   32'(bus.o_dmem_resp_valid), 32'd0);
        tick();
        chk("fetch pulse ends", 32'(bus.o_imem_resp_valid), 32'd0);

        // Both requesting right after reset: D, I, D, I
        do_reset();
        gnt_log.delete();
        bus.i_imem_req_valid = 1'b1; bus.i_imem_addr = 32'h0000_0100;
        bus.i_dmem_req_valid = 1'b1; bus.i_dmem_addr = 32'h0000_0200;
        bus.i_dmem_wen = 1'b0; bus.i_dmem_wdata = 32'd0; bus.i_dmem_mask = 4'hF;
        for (int i = 0; i < 4; i++) serve(32'hC000_0000 + 32'(i), 0);
        bus.i_imem_req_valid = 1'b0;
        bus.i_dmem_req_valid = 1'b0;
        tick();
        chk("rr count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk($sformatf("rr order %0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));

        // Store
        bus.i_dmem_req_valid = 1'b1; bus.i_dmem_addr = 32'h0000_0020;
        bus.i_dmem_wen = 1'b1; bus.i_dmem_wdata = 32'h1234_5678; bus.i_dmem_mask = 4'b1100;
        #1 chk("store ready", 32'(bus.o_dmem_req_ready), 32'd1);
        tick();
        bus.i_dmem_req_valid = 1'b0;
        chk("store wen",   32'(bus.o_mem_wen), 32'd1);
        chk("store addr",  bus.o_mem_addr, 32'h0000_0020);
        chk("store wdata", bus.o_mem_wdata, 32'h1234_5678);
        chk("store mask",  32'(bus.o_mem_mask), 32'hC);
        serve(32'hFFFF_FFFF, 0);
        chk("store resp",  32'(bus.o_dmem_resp_valid), 32'd1);
        chk("store rdata", bus.o_dmem_rdata, 32'd0);
        chk("store no imem", 32'(bus.o_imem_resp_valid), 32'd0);
        bus.i_dmem_wen = 1'b0;
        tick();

        // Downstream backpressure with both requesters waiting
        bus.i_imem_req_valid = 1'b1; bus.i_imem_addr = 32'h0000_0040;
        tick();
        bus.i_imem_addr = 32'h0000_0044;
        bus.i_dmem_req_valid = 1'b1; bus.i_dmem_addr = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp imem_ready", 32'(bus.o_imem_req_ready), 32'd0);
            chk("bp dmem_ready", 32'(bus.o_dmem_req_ready), 32'd0);
            chk("bp busy",       32'(busy), 32'd1);
            chk("bp mem_addr",   bus.o_mem_addr, 32'h0000_0040);
            tick();
        end
        bus.i_imem_req_valid = 1'b0;
        bus.i_dmem_req_valid = 1'b0;
        serve(32'h5555_AAAA, 0);
        chk("bp resp",  32'(bus.o_imem_resp_valid), 32'd1);
        chk("bp rdata", bus.o_imem_rdata, 32'h5555_AAAA);
        tick();

        // Reset while waiting for the downstream response
        bus.i_imem_req_valid = 1'b1; bus.i_imem_addr = 32'h0000_0060;
        tick();
        bus.i_imem_req_valid = 1'b0;
        bus.i_mem_req_ready  = 1'b1;
        tick();
        bus.i_mem_req_ready  = 1'b0;
        chk("wait busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("mid-reset busy",      32'(busy), 32'd0);
        chk("mid-reset mem_valid", 32'(bus.o_mem_req_valid), 32'd0);
        rst_n = 1'b1;
        bus.i_mem_resp_valid = 1'b1;
        bus.i_mem_rdata      = 32'h1212_1212;
        tick();
        bus.i_mem_resp_valid = 1'b0;
        bus.i_mem_rdata      = 32'd0;
        chk("stale imem_resp", 32'(bus.o_imem_resp_valid), 32'd0);
        chk("stale dmem_resp", 32'(bus.o_dmem_resp_valid), 32'd0);
        tick();
        chk("stale imem_resp 2", 32'(bus.o_imem_resp_valid), 32'd0);
        bus.i_imem_req_valid = 1'b1; bus.i_imem_addr = 32'h0000_0064;
        tick();
        bus.i_imem_req_valid = 1'b0;
        serve(32'h0BAD_F00D, 0);
        chk("post-reset resp",  32'(bus.o_imem_resp_valid), 32'd1);
        chk("post-reset rdata", bus.o_imem_rdata, 32'h0BAD_F00D);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
